// File: rtl/dpe_pkg.sv
// Shared sizing and fixed-point helpers for the dot-product engine and
// other fixed-point blocks of the DCT path.
package dpe_pkg;

  localparam int MAX_W = 128;

  typedef struct packed {
    logic             sat;
    logic [MAX_W-1:0] val;
  } rs_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  function automatic int acc_w(input int dw, input int lanes, input int guard);
    return 2 * dw + clog2(lanes) + guard;
  endfunction

  // Round half toward +inf, arithmetic shift right, then clip to out_w signed bits.
  function automatic rs_t round_sat(input logic signed [MAX_W-1:0] x,
                                    input int shift, input int out_w);
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] bias;
    logic signed [MAX_W-1:0] r;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    rs_t                     res;
    one  = {{(MAX_W-1){1'b0}}, 1'b1};
    bias = (one <<< shift) >>> 1;
    r    = (x + bias) >>> shift;
    hi   = (one <<< (out_w - 1)) - one;
    lo   = -(one <<< (out_w - 1));
    res.sat = 1'b0;
    res.val = r;
    if (r > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end else begin
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/dpe_adder_tree.sv
// Registered pairwise signed reduction tree, one register level per halving,
// with valid/last tags travelling alongside the data.
module dpe_adder_tree
  import dpe_pkg::*;
#(
  parameter int  LANES = 8,
  parameter int  IN_W  = 32,
  localparam int T     = clog2(LANES),
  localparam int OUT_W = IN_W + T
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic [LANES*IN_W-1:0] data_i,
  output logic                  valid_o,
  output logic                  last_o,
  output logic [OUT_W-1:0]      data_o
);

  logic [T-1:0] vld_q;
  logic [T-1:0] lst_q;

  for (genvar l = 0; l <= T; l++) begin : g_lvl
    localparam int W = IN_W + l;
    localparam int N = LANES >> l;
    logic [N*W-1:0] node;

    if (l == 0) begin : g_in
      assign node = data_i;
    end else begin : g_add
      // Each level grows one bit so the pairwise sum can never overflow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          node <= '0;
        end else if (en_i) begin
          for (int j = 0; j < N; j++) begin
            node[j*W +: W] <= W'($signed(g_lvl[l-1].node[2*j*(W-1) +: W-1]))
                            + W'($signed(g_lvl[l-1].node[(2*j+1)*(W-1) +: W-1]));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (en_i) begin
      vld_q[0] <= valid_i;
      lst_q[0] <= last_i;
      for (int k = 1; k < T; k++) begin
        vld_q[k] <= vld_q[k-1];
        lst_q[k] <= lst_q[k-1];
      end
    end
  end

  assign valid_o = vld_q[T-1];
  assign last_o  = lst_q[T-1];
  assign data_o  = g_lvl[T].node;

endmodule

// File: rtl/dot_product_engine.sv
// Signed fixed-point dot-product engine: multiply, registered adder tree,
// multi-beat accumulator and round/shift/saturate output with handshakes.
module dot_product_engine
  import dpe_pkg::*;
#(
  parameter int LANES     = 8,
  parameter int DW        = 16,
  parameter int OUT_W     = 32,
  parameter int SHIFT     = 0,
  parameter int ACC_GUARD = 8,
  parameter int BEAT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  input  logic [LANES*DW-1:0]   s_row,
  input  logic [LANES*DW-1:0]   s_col,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_W-1:0]      m_data,
  output logic                  m_sat,
  output logic [BEAT_W-1:0]     m_beats
);

  localparam int T     = clog2(LANES);
  localparam int PW    = 2 * DW;
  localparam int TW    = PW + T;
  localparam int ACC_W = acc_w(DW, LANES, ACC_GUARD);

  logic                  en;
  logic [LANES*PW-1:0]   p_q;
  logic                  p_valid_q;
  logic                  p_last_q;
  logic                  t_valid;
  logic                  t_last;
  logic [TW-1:0]         t_data;
  logic [ACC_W-1:0]      acc_q;
  logic [BEAT_W-1:0]     beats_q;
  logic                  first_q;
  logic                  c_valid_q;
  logic                  c_last_q;
  rs_t                   rnd_d;
  logic                  m_valid_q;
  logic [OUT_W-1:0]      m_data_q;
  logic                  m_sat_q;
  logic [BEAT_W-1:0]     m_beats_q;

  // A single global enable freezes the whole pipeline under backpressure.
  assign en      = !m_valid_q || m_ready;
  assign s_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q       <= '0;
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < LANES; i++) begin
        p_q[i*PW +: PW] <= PW'($signed(s_row[i*DW +: DW])) * PW'($signed(s_col[i*DW +: DW]));
      end
      p_valid_q <= s_valid;
      p_last_q  <= s_valid && s_last;
    end
  end

  dpe_adder_tree #(
    .LANES (LANES),
    .IN_W  (PW)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .valid_i (p_valid_q),
    .last_i  (p_last_q),
    .data_i  (p_q),
    .valid_o (t_valid),
    .last_o  (t_last),
    .data_o  (t_data)
  );

  // first_q marks that the next valid tree result opens a new vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      beats_q   <= '0;
      first_q   <= 1'b1;
      c_valid_q <= 1'b0;
      c_last_q  <= 1'b0;
    end else if (en) begin
      c_valid_q <= t_valid;
      c_last_q  <= t_last;
      if (t_valid) begin
        if (first_q) begin
          acc_q   <= ACC_W'($signed(t_data));
          beats_q <= BEAT_W'(1);
        end else begin
          acc_q <= acc_q + ACC_W'($signed(t_data));
          if (beats_q != '1) begin
            beats_q <= beats_q + BEAT_W'(1);
          end
        end
        first_q <= t_last;
      end
    end
  end

  assign rnd_d = round_sat(MAX_W'($signed(acc_q)), SHIFT, OUT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sat_q   <= 1'b0;
      m_beats_q <= '0;
    end else if (en) begin
      m_valid_q <= c_valid_q && c_last_q;
      if (c_valid_q && c_last_q) begin
        m_data_q  <= OUT_W'(rnd_d.val);
        m_sat_q   <= rnd_d.sat;
        m_beats_q <= beats_q;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_sat   = m_sat_q;
  assign m_beats = m_beats_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed plus randomized bench for dot_product_engine against an
// arithmetic reference model (SHIFT=0 and SHIFT=4 instances).
module tb_dot_product_engine;

  localparam int LANES  = 8;
  localparam int DW     = 16;
  localparam int OUT_W  = 32;
  localparam int BEAT_W = 8;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  logic                     s_valid, s_ready, s_last, m_valid, m_ready, m_sat;
  logic [LANES*DW-1:0]      s_row, s_col;
  logic signed [OUT_W-1:0]  m_data;
  logic [BEAT_W-1:0]        m_beats;
  logic                     f_s_valid, f_s_ready, f_s_last, f_m_valid, f_m_ready, f_m_sat;
  logic [LANES*DW-1:0]      f_s_row, f_s_col;
  logic signed [OUT_W-1:0]  f_m_data;
  logic [BEAT_W-1:0]        f_m_beats;

  dot_product_engine #(.LANES(LANES), .DW(DW), .OUT_W(OUT_W), .SHIFT(0),
                       .ACC_GUARD(8), .BEAT_W(BEAT_W)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_row(s_row), .s_col(s_col), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sat(m_sat), .m_beats(m_beats));

  dot_product_engine #(.LANES(LANES), .DW(DW), .OUT_W(OUT_W), .SHIFT(4),
                       .ACC_GUARD(8), .BEAT_W(BEAT_W)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .s_valid(f_s_valid), .s_ready(f_s_ready), .s_last(f_s_last),
    .s_row(f_s_row), .s_col(f_s_col), .m_valid(f_m_valid), .m_ready(f_m_ready),
    .m_data(f_m_data), .m_sat(f_m_sat), .m_beats(f_m_beats));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint dot(input int r[LANES], input int c[LANES]);
    longint s = 0;
    for (int i = 0; i < LANES; i++) s += longint'(r[i]) * longint'(c[i]);
    return s;
  endfunction

  function automatic longint scaled(input longint sum, input int sh);
    if (sh > 0) return (sum + (longint'(1) <<< (sh - 1))) >>> sh;
    return sum;
  endfunction

  function automatic longint model_res(input longint sum, input int sh);
    longint v = scaled(sum, sh);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint model_sat(input longint sum, input int sh);
    longint v = scaled(sum, sh);
    return (v > MAXV || v < MINV) ? 64'sd1 : 64'sd0;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input bit sel, input int r[LANES], input int c[LANES], input bit last);
    logic [LANES*DW-1:0] rv, cv;
    logic [31:0] t;
    bit ok, done;
    for (int i = 0; i < LANES; i++) begin
      t = r[i]; rv[i*DW +: DW] = t[DW-1:0];
      t = c[i]; cv[i*DW +: DW] = t[DW-1:0];
    end
    if (sel) begin f_s_row = rv; f_s_col = cv; f_s_last = last; f_s_valid = 1'b1; end
    else     begin s_row = rv;   s_col = cv;   s_last = last;   s_valid = 1'b1;   end
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      ok = sel ? f_s_ready : s_ready;
      @(posedge clk);
      #1;
      done = ok;
    end
    if (sel) f_s_valid = 1'b0; else s_valid = 1'b0;
    acc_cyc = cyc;
    if (!done) chk("accept_timeout", 64'sd0, 64'sd1);
  endtask

  task automatic get(input bit sel, output logic signed [63:0] d, output logic signed [63:0] s,
                     output logic signed [63:0] b, output int unsigned at);
    bit got = 1'b0;
    d = 'x; s = 'x; b = 'x; at = 0;
    for (int k = 0; k < 64 && !got; k++) begin
      if (sel ? f_m_valid : m_valid) begin
        got = 1'b1;
        d = sel ? f_m_data : m_data;
        s = sel ? f_m_sat : m_sat;
        b = sel ? f_m_beats : m_beats;
        at = cyc;
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("result_timeout", 64'sd0, 64'sd1);
  endtask

  initial begin
    int r[LANES], c[LANES];
    logic signed [63:0] d, s, b;
    int unsigned at, at2, t0;
    longint sum;
    int nb;
    s_valid = 0; s_last = 0; s_row = '0; s_col = '0; m_ready = 1;
    f_s_valid = 0; f_s_last = 0; f_s_row = '0; f_s_col = '0; f_m_ready = 1;

    tick(3);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_beats", m_beats, 0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_s_ready", s_ready, 1);

    // Single beat, lanes 1..8 times 1; latency counts the accepting edge.
    foreach (r[i]) begin r[i] = i + 1; c[i] = 1; end
    put(0, r, c, 1'b1);
    t0 = acc_cyc;
    get(0, d, s, b, at);
    chk("t1_data", d, model_res(dot(r, c), 0));
    chk("t1_sat", s, model_sat(dot(r, c), 0));
    chk("t1_beats", b, 1);
    chk("t1_latency", at - t0 + 1, 6);

    foreach (r[i]) begin r[i] = -32768; c[i] = -32768; end
    put(0, r, c, 1'b1);
    get(0, d, s, b, at);
    chk("t2_data", d, model_res(dot(r, c), 0));
    chk("t2_sat", s, 1);

    foreach (r[i]) begin r[i] = 2; c[i] = 3; end
    put(0, r, c, 1'b0);
    put(0, r, c, 1'b0);
    put(0, r, c, 1'b1);
    sum = 3 * dot(r, c);
    foreach (r[i]) begin r[i] = 1; c[i] = 1; end
    put(0, r, c, 1'b1);
    get(0, d, s, b, at);
    chk("t3_first_data", d, model_res(sum, 0));
    chk("t3_first_beats", b, 3);
    get(0, d, s, b, at2);
    chk("t3_second_data", d, model_res(dot(r, c), 0));
    chk("t3_second_beats", b, 1);
    chk("t3_consecutive", at2 - at, 1);

    m_ready = 1'b0;
    t0 = cyc;
    for (int k = 1; k <= 4; k++) begin
      foreach (r[i]) begin r[i] = k; c[i] = 1; end
      put(0, r, c, 1'b1);
    end
    while (cyc < t0 + 12) tick(1);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_hold_data", m_data, 8);
    m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      get(0, d, s, b, at);
      chk("bp_order_data", d, 8 * k);
      chk("bp_order_beats", b, 1);
    end
    tick(10);
    chk("bp_no_dup", m_valid, 0);

    foreach (r[i]) begin r[i] = 5; c[i] = 1; end
    put(1, r, c, 1'b1);
    get(1, d, s, b, at);
    chk("sh4_pos", d, model_res(dot(r, c), 4));
    foreach (r[i]) r[i] = -5;
    put(1, r, c, 1'b1);
    get(1, d, s, b, at);
    chk("sh4_neg", d, model_res(dot(r, c), 4));
    chk("sh4_neg_sat", s, 0);

    foreach (r[i]) begin r[i] = 1; c[i] = 1; end
    put(0, r, c, 1'b0);
    put(0, r, c, 1'b0);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_m_beats", m_beats, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    foreach (r[i]) begin r[i] = (i == 0) ? 5 : 0; c[i] = 1; end
    put(0, r, c, 1'b1);
    get(0, d, s, b, at);
    chk("post_rst_data", d, 5);
    chk("post_rst_beats", b, 1);
    tick(10);
    chk("post_rst_no_extra", m_valid, 0);

    for (int v = 0; v < 8; v++) begin
      nb = $urandom_range(1, 3);
      sum = 0;
      for (int bt = 0; bt < nb; bt++) begin
        foreach (r[i]) begin
          if (v % 2 == 1) begin
            r[i] = int'($urandom_range(0, 65535)) - 32768;
            c[i] = int'($urandom_range(0, 65535)) - 32768;
          end else begin
            r[i] = int'($urandom_range(0, 200)) - 100;
            c[i] = int'($urandom_range(0, 200)) - 100;
          end
        end
        sum += dot(r, c);
        put(0, r, c, bt == nb - 1);
      end
      get(0, d, s, b, at);
      chk("rand_data", d, model_res(sum, 0));
      chk("rand_sat", s, model_sat(sum, 0));
      chk("rand_beats", b, nb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
